// File: rtl/video_dram_arb_if.sv
// rtl/video_dram_arb_if.sv - requester/DRAM-command bundle for the video DRAM slot arbiter
interface video_dram_arb_if #(
  parameter int AW = 21
);
  logic [AW-1:0] video_addr;
  logic [4:0]    video_bw;
  logic          video_go;
  logic [AW-1:0] ts_addr;
  logic          ts_req;
  logic          ts_z80_lp;
  logic [AW-1:0] tm_addr;
  logic          tm_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [15:0]   cpu_wdata;
  logic [AW-1:0] dram_addr;
  logic          dram_req;
  logic          dram_rnw;
  logic [15:0]   dram_wdata;
  logic          video_pre_next;
  logic          video_next;
  logic          next_video;
  logic          video_strobe;
  logic          tm_next;
  logic          ts_pre_next;
  logic          ts_next;
  logic          cpu_next;
  logic          cpu_strobe;
  logic [1:0]    slot_phase;

  modport master (
    output video_addr, video_bw, video_go, ts_addr, ts_req, ts_z80_lp,
           tm_addr, tm_req, cpu_addr, cpu_req, cpu_rnw, cpu_wdata,
    input  dram_addr, dram_req, dram_rnw, dram_wdata, video_pre_next, video_next,
           next_video, video_strobe, tm_next, ts_pre_next, ts_next, cpu_next,
           cpu_strobe, slot_phase
  );

  modport slave (
    input  video_addr, video_bw, video_go, ts_addr, ts_req, ts_z80_lp,
           tm_addr, tm_req, cpu_addr, cpu_req, cpu_rnw, cpu_wdata,
    output dram_addr, dram_req, dram_rnw, dram_wdata, video_pre_next, video_next,
           next_video, video_strobe, tm_next, ts_pre_next, ts_next, cpu_next,
           cpu_strobe, slot_phase
  );
endinterface

// File: rtl/video_dram_arb.sv
// rtl/video_dram_arb.sv - fixed-slot DRAM arbiter for video burst, tile-map, tile-sprite and CPU
module video_dram_arb #(
  parameter int PHASES = 4,
  parameter int AW     = 21
) (
  input logic             clk,
  input logic             res_n,
  video_dram_arb_if.slave bus
);
  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] PH_LOOK = PW'(PHASES - 3);
  localparam logic [PW-1:0] PH_PRE  = PW'(PHASES - 2);
  localparam logic [PW-1:0] PH_DEC  = PW'(PHASES - 1);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_VIDEO,
    OWN_CPU,
    OWN_TM,
    OWN_TS
  } owner_t;

  logic [PW-1:0] r_phase;
  owner_t        r_owner;
  logic [5:0]    r_burst_cnt;
  logic [AW-1:0] r_dram_addr;
  logic          r_dram_req;
  logic          r_dram_rnw;
  logic [15:0]   r_dram_wdata;
  logic          r_video_pre_next;
  logic          r_ts_pre_next;
  logic          r_video_strobe;
  logic          r_tm_next;
  logic          r_ts_next;
  logic          r_cpu_strobe;

  logic          w_decide;
  logic          w_burst_start;
  owner_t        w_win;
  owner_t        w_owner_next;
  logic [5:0]    w_burst_cnt_next;

  // Winner is evaluated every cycle; it only takes effect at the decision
  // phase, but the phase-1 evaluation also feeds the video look-ahead strobe.
  always_comb begin
    w_decide      = (r_phase == PH_DEC);
    w_burst_start = bus.video_go && (r_burst_cnt == 6'd0);
    w_win         = OWN_NONE;
    if ((r_burst_cnt != 6'd0) || w_burst_start)  w_win = OWN_VIDEO;
    else if (bus.cpu_req && bus.ts_z80_lp)       w_win = OWN_CPU;
    else if (bus.tm_req)                         w_win = OWN_TM;
    else if (bus.ts_req)                         w_win = OWN_TS;
    else if (bus.cpu_req)                        w_win = OWN_CPU;
  end

  always_comb begin
    w_owner_next     = r_owner;
    w_burst_cnt_next = r_burst_cnt;
    if (w_decide) begin
      w_owner_next = w_win;
      // The first word of a new burst is granted in the same decision.
      if (w_burst_start)
        w_burst_cnt_next = {1'b0, bus.video_bw};
      else if (r_burst_cnt != 6'd0)
        w_burst_cnt_next = r_burst_cnt - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_phase          <= '0;
      r_owner          <= OWN_NONE;
      r_burst_cnt      <= 6'd0;
      r_dram_addr      <= '0;
      r_dram_req       <= 1'b0;
      r_dram_rnw       <= 1'b0;
      r_dram_wdata     <= 16'd0;
      r_video_pre_next <= 1'b0;
      r_ts_pre_next    <= 1'b0;
      r_video_strobe   <= 1'b0;
      r_tm_next        <= 1'b0;
      r_ts_next        <= 1'b0;
      r_cpu_strobe     <= 1'b0;
    end else begin
      r_phase     <= r_phase + PW'(1);
      r_owner     <= w_owner_next;
      r_burst_cnt <= w_burst_cnt_next;

      if (w_decide) begin
        r_dram_req <= (w_win != OWN_NONE);
        case (w_win)
          OWN_VIDEO: begin
            r_dram_addr <= bus.video_addr;
            r_dram_rnw  <= 1'b1;
          end
          OWN_CPU: begin
            r_dram_addr  <= bus.cpu_addr;
            r_dram_rnw   <= bus.cpu_rnw;
            r_dram_wdata <= bus.cpu_wdata;
          end
          OWN_TM: begin
            r_dram_addr <= bus.tm_addr;
            r_dram_rnw  <= 1'b1;
          end
          OWN_TS: begin
            r_dram_addr <= bus.ts_addr;
            r_dram_rnw  <= 1'b1;
          end
          default: ;
        endcase
      end

      r_video_pre_next <= (r_phase == PH_LOOK) && (w_win == OWN_VIDEO);
      r_ts_pre_next    <= (r_phase == PH_LOOK) && (r_owner == OWN_TS);
      r_video_strobe   <= (r_phase == PH_PRE) && (r_owner == OWN_VIDEO);
      r_tm_next        <= (r_phase == PH_PRE) && (r_owner == OWN_TM);
      r_ts_next        <= (r_phase == PH_PRE) && (r_owner == OWN_TS);
      r_cpu_strobe     <= (r_phase == PH_PRE) && (r_owner == OWN_CPU) && r_dram_rnw;
    end
  end

  assign bus.dram_addr      = r_dram_addr;
  assign bus.dram_req       = r_dram_req;
  assign bus.dram_rnw       = r_dram_rnw;
  assign bus.dram_wdata     = r_dram_wdata;
  assign bus.video_pre_next = r_video_pre_next;
  assign bus.video_next     = w_decide && (w_win == OWN_VIDEO);
  assign bus.cpu_next       = w_decide && (w_win == OWN_CPU);
  assign bus.next_video     = (r_owner == OWN_VIDEO);
  assign bus.video_strobe   = r_video_strobe;
  assign bus.tm_next        = r_tm_next;
  assign bus.ts_pre_next    = r_ts_pre_next;
  assign bus.ts_next        = r_ts_next;
  assign bus.cpu_strobe     = r_cpu_strobe;
  assign bus.slot_phase     = r_phase;
endmodule

// File: tb/tb_video_dram_arb.sv
// tb/tb_video_dram_arb.sv - slot-table checks of video_dram_arb plus burst-length and reset sequences
module tb_video_dram_arb;
  typedef enum logic [2:0] {N, V, C, T, S} own_t;

  typedef struct {
    logic        go;
    logic [4:0]  bw;
    logic        tm, ts, cpu, rnw, lp;
    logic [15:0] wd;
    own_t        own;
    own_t        win;
    logic [20:0] addr;
    logic        drnw;
    logic [15:0] dwd;
  } vec_t;

  localparam logic [20:0] VA = 21'h1AAAA;
  localparam logic [20:0] TA = 21'h00111;
  localparam logic [20:0] SA = 21'h00222;
  localparam logic [20:0] CA = 21'h00333;

  logic clk;
  logic res_n;
  int   n_pass;
  int   n_total;
  int   cnt_nv, cnt_vn, cnt_vs;
  vec_t tbl[24];

  video_dram_arb_if #(.AW(21)) bus ();

  video_dram_arb #(.PHASES(4), .AW(21)) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic go, input logic [4:0] bw, input logic tm, input logic ts,
                              input logic cpu, input logic rnw, input logic lp, input logic [15:0] wd,
                              input own_t own, input own_t win, input logic [20:0] addr,
                              input logic drnw, input logic [15:0] dwd);
    vec_t v;
    v.go = go; v.bw = bw; v.tm = tm; v.ts = ts; v.cpu = cpu; v.rnw = rnw; v.lp = lp; v.wd = wd;
    v.own = own; v.win = win; v.addr = addr; v.drnw = drnw; v.dwd = dwd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.video_go  = v.go;
    bus.video_bw  = v.bw;
    bus.tm_req    = v.tm;
    bus.ts_req    = v.ts;
    bus.cpu_req   = v.cpu;
    bus.cpu_rnw   = v.rnw;
    bus.ts_z80_lp = v.lp;
    bus.cpu_wdata = v.wd;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    bus.video_addr = VA; bus.tm_addr = TA; bus.ts_addr = SA; bus.cpu_addr = CA;
    res_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 16'h0F0F, N, N, 0, 0, 0));

    //       go bw  tm ts cpu rnw lp wd        own win addr drnw dwd
    tbl[0]  = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, N, N, 21'h0, 0, 16'h0000);
    tbl[1]  = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, N, N, 21'h0, 0, 16'h0000);
    tbl[2]  = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, N, N, 21'h0, 0, 16'h0000);
    tbl[3]  = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, N, N, 21'h0, 0, 16'h0000);
    tbl[4]  = mk(1, 3,  1, 0, 0,  0,  0, 16'h0F0F, N, V, 21'h0, 0, 16'h0000);
    tbl[5]  = mk(0, 3,  1, 0, 0,  0,  0, 16'h0F0F, V, V, VA,    1, 16'h0000);
    tbl[6]  = mk(0, 3,  1, 0, 0,  0,  0, 16'h0F0F, V, V, VA,    1, 16'h0000);
    tbl[7]  = mk(0, 3,  1, 0, 0,  0,  0, 16'h0F0F, V, V, VA,    1, 16'h0000);
    tbl[8]  = mk(0, 3,  1, 0, 0,  0,  0, 16'h0F0F, V, T, VA,    1, 16'h0000);
    tbl[9]  = mk(0, 0,  1, 0, 0,  0,  0, 16'h0F0F, T, T, TA,    1, 16'h0000);
    tbl[10] = mk(0, 0,  1, 1, 1,  1,  0, 16'h0F0F, T, T, TA,    1, 16'h0000);
    tbl[11] = mk(0, 0,  1, 1, 1,  1,  0, 16'h0F0F, T, T, TA,    1, 16'h0000);
    tbl[12] = mk(0, 0,  0, 1, 1,  1,  0, 16'h0F0F, T, S, TA,    1, 16'h0000);
    tbl[13] = mk(0, 0,  0, 1, 1,  1,  0, 16'h0F0F, S, S, SA,    1, 16'h0000);
    tbl[14] = mk(0, 0,  0, 0, 1,  1,  0, 16'h0F0F, S, C, SA,    1, 16'h0000);
    tbl[15] = mk(0, 0,  0, 0, 0,  1,  0, 16'h0F0F, C, N, CA,    1, 16'h0F0F);
    tbl[16] = mk(0, 0,  0, 1, 1,  0,  1, 16'hA55A, N, C, CA,    1, 16'h0F0F);
    tbl[17] = mk(0, 0,  0, 1, 0,  0,  1, 16'h0F0F, C, S, CA,    0, 16'hA55A);
    tbl[18] = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, S, N, SA,    1, 16'hA55A);
    tbl[19] = mk(0, 0,  0, 0, 0,  0,  0, 16'h0F0F, N, N, SA,    1, 16'hA55A);
    tbl[20] = mk(1, 1,  0, 0, 0,  0,  0, 16'h0F0F, N, V, SA,    1, 16'hA55A);
    tbl[21] = mk(1, 1,  0, 0, 0,  0,  0, 16'h0F0F, V, V, VA,    1, 16'hA55A);
    tbl[22] = mk(0, 1,  0, 0, 0,  0,  0, 16'h0F0F, V, N, VA,    1, 16'hA55A);
    tbl[23] = mk(0, 1,  0, 0, 0,  0,  0, 16'h0F0F, N, N, VA,    1, 16'hA55A);

    @(negedge clk); #1;
    chk("rst_phase", 0, 32'(bus.slot_phase), 0);
    chk("rst_req",   0, 32'(bus.dram_req), 0);
    chk("rst_addr",  0, 32'(bus.dram_addr), 0);
    chk("rst_strb",  0, 32'({bus.video_strobe, bus.tm_next, bus.ts_next, bus.cpu_strobe,
                             bus.video_pre_next, bus.ts_pre_next, bus.next_video}), 0);
    @(negedge clk);
    res_n = 1'b1;

    for (int r = 0; r < 24; r++) begin
      drive(tbl[r]);
      for (int p = 0; p < 4; p++) begin
        #1;
        chk("phase",     r, 32'(bus.slot_phase), 32'(p));
        chk("dram_req",  r, 32'(bus.dram_req), 32'(tbl[r].own != N));
        chk("next_vid",  r, 32'(bus.next_video), 32'(tbl[r].own == V));
        chk("vid_strb",  r, 32'(bus.video_strobe), 32'(p == 3 && tbl[r].own == V));
        chk("tm_next",   r, 32'(bus.tm_next), 32'(p == 3 && tbl[r].own == T));
        chk("ts_next",   r, 32'(bus.ts_next), 32'(p == 3 && tbl[r].own == S));
        chk("cpu_strb",  r, 32'(bus.cpu_strobe), 32'(p == 3 && tbl[r].own == C && tbl[r].drnw));
        chk("vid_next",  r, 32'(bus.video_next), 32'(p == 3 && tbl[r].win == V));
        chk("cpu_next",  r, 32'(bus.cpu_next), 32'(p == 3 && tbl[r].win == C));
        chk("vid_pre",   r, 32'(bus.video_pre_next), 32'(p == 2 && tbl[r].win == V));
        chk("ts_pre",    r, 32'(bus.ts_pre_next), 32'(p == 2 && tbl[r].own == S));
        if (p == 0) begin
          chk("dram_addr",  r, 32'(bus.dram_addr), 32'(tbl[r].addr));
          chk("dram_rnw",   r, 32'(bus.dram_rnw), 32'(tbl[r].drnw));
          chk("dram_wdata", r, 32'(bus.dram_wdata), 32'(tbl[r].dwd));
        end
        @(negedge clk);
      end
    end

    // Longest burst: one request slot then 36 idle slots must hold exactly 32 video slots.
    cnt_nv = 0; cnt_vn = 0; cnt_vs = 0;
    drive(mk(1, 31, 0, 0, 0, 0, 0, 16'h0F0F, N, N, 0, 0, 0));
    for (int c = 0; c < 148; c++) begin
      if (c == 4) bus.video_go = 1'b0;
      #1;
      if (bus.next_video)   cnt_nv++;
      if (bus.video_next)   cnt_vn++;
      if (bus.video_strobe) cnt_vs++;
      @(negedge clk);
    end
    chk("bw31_slot_clks", 0, 32'(cnt_nv), 128);
    chk("bw31_next",      0, 32'(cnt_vn), 32);
    chk("bw31_strobe",    0, 32'(cnt_vs), 32);

    // Reset at phase 1 of a TS slot, then sole TS requester after release.
    bus.ts_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_phase", 0, 32'(bus.slot_phase), 1);
    chk("pre_rst_req",   0, 32'(bus.dram_req), 1);
    res_n = 1'b0;
    #1;
    chk("mid_rst_req",   0, 32'(bus.dram_req), 0);
    chk("mid_rst_phase", 0, 32'(bus.slot_phase), 0);
    @(negedge clk);
    @(negedge clk);
    chk("in_rst_ts", 0, 32'(bus.ts_next), 0);
    res_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("rel_ts_next", c, 32'(bus.ts_next), 32'(c == 7 || c == 11));
      chk("rel_req",     c, 32'(bus.dram_req), 32'(c >= 4));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
